// File: rtl/if_id_fetch_queue.sv
// if_id_fetch_queue: in-order IF->ID queue with flush/kill squash and NOP when empty
module if_id_fetch_queue #(
  parameter int XLEN = 32,
  parameter int ILEN = 32,
  parameter int DEPTH = 4,
  parameter logic [ILEN-1:0] NOP_INST = '0,
  parameter logic [XLEN-1:0] PC_INC = XLEN'(4)
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     if_valid,
  input  logic [ILEN-1:0]          if_inst,
  input  logic [XLEN-1:0]          if_pc,
  input  logic                     if_take,
  output logic                     if_ready,
  output logic                     id_valid,
  output logic [ILEN-1:0]          id_inst,
  output logic [XLEN-1:0]          id_pc,
  output logic                     id_take,
  input  logic                     id_ready,
  input  logic                     flush,
  input  logic                     id_kill,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  logic [ILEN-1:0] inst_mem [DEPTH];
  logic [XLEN-1:0] pc_mem [DEPTH];
  logic            take_mem [DEPTH];
  logic [AW-1:0]   wr_ptr, rd_ptr;
  logic            push, pop;
  always_comb begin
    if_ready = count != CW'(DEPTH);
    id_valid = count != '0;
    id_inst  = id_valid ? inst_mem[rd_ptr] : NOP_INST;
    id_pc    = id_valid ? pc_mem[rd_ptr] : '0;
    id_take  = id_valid ? take_mem[rd_ptr] : 1'b0;
    push     = if_valid & if_ready & ~flush & ~id_kill;
    pop      = id_valid & id_ready & ~flush;
  end
  always_ff @(posedge clk) begin
    if (push) begin
      inst_mem[wr_ptr] <= if_inst;
      pc_mem[wr_ptr]   <= if_pc + PC_INC;
      take_mem[wr_ptr] <= if_take;
    end
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= rd_ptr;
      count  <= '0;
    end else if (id_kill) begin
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
        wr_ptr <= rd_ptr + AW'(1);
        count  <= '0;
      end else if (count != '0) begin
        wr_ptr <= rd_ptr + AW'(1);
        count  <= CW'(1);
      end
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop) rd_ptr <= rd_ptr + AW'(1);
      count <= count + CW'(push) - CW'(pop);
    end
  end
endmodule

// File: tb/tb_if_id_fetch_queue.sv
// tb_if_id_fetch_queue: directed and random checks against a queue-based reference model
module tb_if_id_fetch_queue;
  localparam int DEPTH = 4;
  typedef struct {
    logic [31:0] inst;
    logic [31:0] pc;
    logic        take;
  } ent_t;
  logic        clk = 1'b0;
  logic        reset, if_valid, if_take, if_ready, id_valid, id_take, id_ready, flush, id_kill;
  logic [31:0] if_inst, if_pc, id_inst, id_pc;
  logic [2:0]  count;
  ent_t        q[$];
  int          checks = 0;
  int          failures = 0;
  if_id_fetch_queue dut (
    .clk(clk), .reset(reset), .if_valid(if_valid), .if_inst(if_inst), .if_pc(if_pc),
    .if_take(if_take), .if_ready(if_ready), .id_valid(id_valid), .id_inst(id_inst),
    .id_pc(id_pc), .id_take(id_take), .id_ready(id_ready), .flush(flush),
    .id_kill(id_kill), .count(count)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic chk_all(input string tag);
    bit e;
    e = q.size() == 0;
    chk({tag, ".count"}, 64'(count), 64'(q.size()));
    chk({tag, ".if_ready"}, 64'(if_ready), 64'(q.size() != DEPTH));
    chk({tag, ".id_valid"}, 64'(id_valid), 64'(!e));
    chk({tag, ".id_inst"}, 64'(id_inst), e ? 64'(0) : 64'(q[0].inst));
    chk({tag, ".id_pc"}, 64'(id_pc), e ? 64'(0) : 64'(q[0].pc));
    chk({tag, ".id_take"}, 64'(id_take), e ? 64'(0) : 64'(q[0].take));
  endtask
  task automatic cyc(input string tag, input logic v, input logic [31:0] inst, input logic [31:0] pc,
                     input logic tk, input logic rdy, input logic fl, input logic kl, input logic rs);
    bit can_push, has;
    ent_t n;
    reset = rs; if_valid = v; if_inst = inst; if_pc = pc; if_take = tk;
    id_ready = rdy; flush = fl; id_kill = kl;
    @(posedge clk);
    has = q.size() != 0;
    can_push = q.size() < DEPTH;
    n.inst = inst; n.pc = pc + 32'd4; n.take = tk;
    if (rs || fl) q.delete();
    else if (kl) begin
      if (has && rdy) q.delete();
      else if (has) q = q[0:0];
    end else begin
      if (has && rdy) void'(q.pop_front());
      if (v && can_push) q.push_back(n);
    end
    @(negedge clk);
    chk_all(tag);
  endtask
  initial begin
    cyc("rst", 0, 0, 0, 0, 0, 0, 0, 1);
    chk("rst.nop", 64'(id_inst), 64'(0));
    cyc("t1.push", 1, 32'h00500093, 32'h100, 0, 0, 0, 0, 0);
    chk("t1.inst", 64'(id_inst), 64'h00500093);
    chk("t1.pc", 64'(id_pc), 64'h104);
    cyc("t1.pop", 0, 0, 0, 0, 1, 0, 0, 0);
    for (int i = 0; i < 5; i++) cyc("t2.fill", 1, 32'h1000 + i, 32'(i * 4), i[0], 0, 0, 0, 0);
    chk("t2.full", 64'(if_ready), 64'(0));
    for (int i = 0; i < 4; i++) begin
      chk("t2.order", 64'(id_pc), 64'(4 + 4 * i));
      cyc("t2.drain", 0, 0, 0, 0, 1, 0, 0, 0);
    end
    for (int i = 0; i < 10; i++) begin
      cyc("t3.wrap", 1, 32'h2000 + i, 32'h200 + 32'(i * 4), 0, 1, 0, 0, 0);
      chk("t3.pc", 64'(id_pc), 64'h204 + 64'(i * 4));
    end
    cyc("t3.pop", 0, 0, 0, 0, 1, 0, 0, 0);
    for (int i = 0; i < 3; i++) cyc("t4.fill", 1, 32'h3000 + i, 32'h300 + 32'(i * 4), 1, 0, 0, 0, 0);
    cyc("t4.flush", 1, 32'h3fff, 32'h3fc, 0, 1, 1, 0, 0);
    chk("t4.cnt", 64'(count), 64'(0));
    cyc("t4.push", 1, 32'h3abc, 32'h500, 1, 0, 0, 0, 0);
    chk("t4.pc", 64'(id_pc), 64'h504);
    cyc("t4.pop", 0, 0, 0, 0, 1, 0, 0, 0);
    for (int i = 0; i < 3; i++) cyc("t5.fill", 1, 32'h4000 + i, 32'h400 + 32'(i * 4), 0, 0, 0, 0, 0);
    cyc("t5.kill", 1, 32'h4fff, 32'h4fc, 1, 0, 0, 1, 0);
    chk("t5.head", 64'(id_pc), 64'h404);
    chk("t5.cnt", 64'(count), 64'(1));
    cyc("t5.killpop", 1, 32'h4eee, 32'h4ec, 1, 1, 0, 1, 0);
    chk("t5.empty", 64'(id_valid), 64'(0));
    cyc("t5.kempty", 1, 32'h4ddd, 32'h4dc, 1, 1, 0, 1, 0);
    for (int i = 0; i < 2; i++) cyc("t6.fill", 1, 32'h5000 + i, 32'h600 + 32'(i * 4), 1, 0, 0, 0, 0);
    cyc("t6.reset", 1, 32'h5fff, 32'h5fc, 1, 1, 0, 0, 1);
    chk("t6.rdy", 64'(if_ready), 64'(1));
    cyc("t6.wrap", 1, 32'h6000, 32'hFFFFFFFC, 1, 0, 0, 0, 0);
    chk("t6.pc", 64'(id_pc), 64'(0));
    for (int i = 0; i < 500; i++)
      cyc("rnd", $urandom_range(0, 3) != 0, $urandom, $urandom, 1'($urandom), $urandom_range(0, 2) != 0,
          $urandom_range(0, 14) == 0, $urandom_range(0, 14) == 0, $urandom_range(0, 60) == 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
